// File: rtl/time_keeper_bcd_pkg.sv
// Shared definitions for the BCD time keeper: mode encodings, digit width,
// field limits and helpers that split a decimal constant into BCD digits.
package clock_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_HR  = 2'b01,
    MODE_SET_MIN = 2'b10
  } mode_t;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HR24_MAX = 23;
  localparam int HR12_MAX = 12;
  localparam int HR12_MIN = 1;

  // Tens digit of a two-digit decimal constant.
  function automatic logic [DIGIT_W-1:0] tens_of(input int value);
    return DIGIT_W'(value / 10);
  endfunction

  // Ones digit of a two-digit decimal constant.
  function automatic logic [DIGIT_W-1:0] ones_of(input int value);
    return DIGIT_W'(value % 10);
  endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD counter. Counts MIN_VAL..MAX_VAL and wraps back to MIN_VAL.
// o_carry_out is high in the cycle an increment wraps the counter; the
// caller decides whether that carry is used.
module bcd_pair_counter
  import clock_pkg::*;
#(
  parameter int MAX_VAL = 59,
  parameter int MIN_VAL = 0,
  parameter int RST_VAL = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_inc,
  input  logic               i_clr,
  output logic [DIGIT_W-1:0] o_ones,
  output logic [DIGIT_W-1:0] o_tens,
  output logic               o_carry_out
);

  localparam logic [DIGIT_W-1:0] MAX_T = tens_of(MAX_VAL);
  localparam logic [DIGIT_W-1:0] MAX_O = ones_of(MAX_VAL);
  localparam logic [DIGIT_W-1:0] MIN_T = tens_of(MIN_VAL);
  localparam logic [DIGIT_W-1:0] MIN_O = ones_of(MIN_VAL);
  localparam logic [DIGIT_W-1:0] RST_T = tens_of(RST_VAL);
  localparam logic [DIGIT_W-1:0] RST_O = ones_of(RST_VAL);

  logic [DIGIT_W-1:0] r_ones;
  logic [DIGIT_W-1:0] r_tens;
  logic               w_at_max;

  assign w_at_max    = (r_tens == MAX_T) && (r_ones == MAX_O);
  assign o_carry_out = i_inc && w_at_max;
  assign o_ones      = r_ones;
  assign o_tens      = r_tens;

  // Clear beats increment; increment wraps at MAX or steps the BCD pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ones <= RST_O;
      r_tens <= RST_T;
    end else if (i_clr) begin
      r_ones <= MIN_O;
      r_tens <= MIN_T;
    end else if (i_inc) begin
      if (w_at_max) begin
        r_ones <= MIN_O;
        r_tens <= MIN_T;
      end else if (r_ones == 4'd9) begin
        r_ones <= 4'd0;
        r_tens <= r_tens + 4'd1;
      end else begin
        r_ones <= r_ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/time_keeper_bcd.sv
// Hours:minutes:seconds keeper in BCD driven by a slow square wave.
// The square wave is synchronised, each rising edge becomes a one-cycle tick,
// and a small mode FSM lets two buttons set hours and minutes.
module time_keeper_bcd
  import clock_pkg::*;
#(
  parameter int HOURS_24    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_in,
  input  logic               btn_mode,
  input  logic               btn_up,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] hr_ones,
  output logic [DIGIT_W-1:0] hr_tens,
  output logic [1:0]         mode,
  output logic               sec_pulse
);

  localparam int HR_MAX = (HOURS_24 != 0) ? HR24_MAX : HR12_MAX;
  localparam int HR_MIN = (HOURS_24 != 0) ? 0 : HR12_MIN;
  localparam int HR_RST = (HOURS_24 != 0) ? 0 : HR12_MAX;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_vld;
  logic                   r_edge;
  logic                   r_armed;
  logic                   w_sync_out;
  logic                   w_tick;

  mode_t r_mode;
  mode_t r_mode_next;
  logic  r_sec_pulse;
  logic  w_sec_inc;
  logic  w_sec_clr;
  logic  w_min_btn;
  logic  w_hr_btn;
  logic  w_sec_carry;
  logic  w_min_carry;

  // Synchroniser chain for tick_in; r_vld tracks which stages hold real
  // samples rather than reset zeros.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      // One synchroniser stage plus its matching valid bit.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_sync[gi] <= 1'b0;
          r_vld[gi]  <= 1'b0;
        end else begin
          r_sync[gi] <= (gi == 0) ? tick_in : r_sync[(gi == 0) ? 0 : gi - 1];
          r_vld[gi]  <= (gi == 0) ? 1'b1    : r_vld[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  // Edge register, and an arm flag that needs a genuine low sample first so a
  // level that was already high across reset never counts as a rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_edge  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_edge  <= w_sync_out;
      r_armed <= r_armed | (r_vld[SYNC_STAGES-1] & ~w_sync_out);
    end
  end

  assign w_tick = w_sync_out & ~r_edge & r_armed;

  // Mode state register and the registered seconds pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode      <= MODE_RUN;
      r_sec_pulse <= 1'b0;
    end else begin
      r_mode      <= r_mode_next;
      r_sec_pulse <= w_sec_inc;
    end
  end

  // Next mode and per-field increment/clear requests; btn_mode wins over btn_up.
  always_comb begin
    r_mode_next = r_mode;
    w_sec_inc   = 1'b0;
    w_sec_clr   = 1'b0;
    w_min_btn   = 1'b0;
    w_hr_btn    = 1'b0;
    case (r_mode)
      MODE_RUN: begin
        w_sec_inc = w_tick;
        if (btn_mode) r_mode_next = MODE_SET_HR;
      end
      MODE_SET_HR: begin
        if (btn_mode)    r_mode_next = MODE_SET_MIN;
        else if (btn_up) w_hr_btn    = 1'b1;
      end
      MODE_SET_MIN: begin
        if (btn_mode) begin
          r_mode_next = MODE_RUN;
          w_sec_clr   = 1'b1;
        end else if (btn_up) begin
          w_min_btn = 1'b1;
        end
      end
      default: r_mode_next = MODE_RUN;
    endcase
  end

  bcd_pair_counter #(.MAX_VAL(SEC_MAX), .MIN_VAL(0), .RST_VAL(0)) u_sec (
    .clk         (clk),
    .reset       (reset),
    .i_inc       (w_sec_inc),
    .i_clr       (w_sec_clr),
    .o_ones      (sec_ones),
    .o_tens      (sec_tens),
    .o_carry_out (w_sec_carry)
  );

  bcd_pair_counter #(.MAX_VAL(MIN_MAX), .MIN_VAL(0), .RST_VAL(0)) u_min (
    .clk         (clk),
    .reset       (reset),
    .i_inc       (w_sec_carry | w_min_btn),
    .i_clr       (1'b0),
    .o_ones      (min_ones),
    .o_tens      (min_tens),
    .o_carry_out (w_min_carry)
  );

  bcd_pair_counter #(.MAX_VAL(HR_MAX), .MIN_VAL(HR_MIN), .RST_VAL(HR_RST)) u_hr (
    .clk         (clk),
    .reset       (reset),
    .i_inc       (w_min_carry | w_hr_btn),
    .i_clr       (1'b0),
    .o_ones      (hr_ones),
    .o_tens      (hr_tens),
    .o_carry_out ()
  );

  assign mode      = r_mode;
  assign sec_pulse = r_sec_pulse;

endmodule

// File: tb/tb_time_keeper_bcd.sv
// Directed bench for time_keeper_bcd: a 24-hour and a 12-hour instance share
// the same stimulus; each step checks hand-computed BCD time, mode and pulse.
module tb_time_keeper_bcd;

  logic clk = 1'b0;
  logic reset;
  logic tick_in;
  logic btn_mode;
  logic btn_up;

  logic [3:0] s1_a, s10_a, m1_a, m10_a, h1_a, h10_a;
  logic [1:0] mode_a;
  logic       pulse_a;
  logic [3:0] s1_b, s10_b, m1_b, m10_b, h1_b, h10_b;
  logic [1:0] mode_b;
  logic       pulse_b;

  logic [23:0] time24;
  logic [23:0] time12;

  int n_assert = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;

  always #5 clk = ~clk;

  time_keeper_bcd #(.HOURS_24(1), .SYNC_STAGES(2)) dut24 (
    .clk(clk), .reset(reset), .tick_in(tick_in), .btn_mode(btn_mode), .btn_up(btn_up),
    .sec_ones(s1_a), .sec_tens(s10_a), .min_ones(m1_a), .min_tens(m10_a),
    .hr_ones(h1_a), .hr_tens(h10_a), .mode(mode_a), .sec_pulse(pulse_a)
  );

  time_keeper_bcd #(.HOURS_24(0), .SYNC_STAGES(2)) dut12 (
    .clk(clk), .reset(reset), .tick_in(tick_in), .btn_mode(btn_mode), .btn_up(btn_up),
    .sec_ones(s1_b), .sec_tens(s10_b), .min_ones(m1_b), .min_tens(m10_b),
    .hr_ones(h1_b), .hr_tens(h10_b), .mode(mode_b), .sec_pulse(pulse_b)
  );

  assign time24 = {h10_a, h1_a, m10_a, m1_a, s10_a, s1_a};
  assign time12 = {h10_b, h1_b, m10_b, m1_b, s10_b, s1_b};

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_assert++;
    assert (obs === exp)
      $display("check %-20s observed %06h expected %06h", tag, obs, exp);
    else begin
      n_fail++;
      $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (pulse_a) pulse_cnt++;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
  endtask

  task automatic press_up();
    btn_up = 1'b1;
    step();
    btn_up = 1'b0;
  endtask

  // One full tick_in period: high for 2 clocks, low for 3.
  task automatic pulse_tick();
    tick_in = 1'b1;
    repeat (2) step();
    tick_in = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    int exp_sec;
    reset    = 1'b1;
    tick_in  = 1'b0;
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    repeat (3) step();
    chk("rst_time24", time24, 24'h000000);
    chk("rst_time12", time12, 24'h120000);
    chk("rst_mode", {22'd0, mode_a}, 24'd0);
    chk("rst_pulse", {23'd0, pulse_a}, 24'd0);
    reset = 1'b0;
    repeat (3) step();

    // Square wave, period 20 clk: pulse 3 clk after each rise.
    tick_in = 1'b1;
    for (int c = 1; c < 60; c++) begin
      step();
      exp_sec = (c >= 3) ? ((c - 3) / 20 + 1) : 0;
      chk($sformatf("sq_pulse_c%0d", c), {23'd0, pulse_a}, {23'd0, (c % 20) == 3});
      chk($sformatf("sq_time_c%0d", c), time24, 24'(exp_sec));
      tick_in = ((c % 20) < 10);
    end
    repeat (4) step();

    // Set 23:59:00 then run to 23:59:58 and across midnight.
    press_mode();
    chk("set_hr_mode", {22'd0, mode_a}, 24'd1);
    repeat (23) press_up();
    press_mode();
    chk("set_min_mode", {22'd0, mode_a}, 24'd2);
    repeat (59) press_up();
    press_mode();
    chk("forced_235900", time24, 24'h235900);
    chk("back_to_run", {22'd0, mode_a}, 24'd0);
    repeat (58) pulse_tick();
    chk("run_235958", time24, 24'h235958);
    pulse_cnt = 0;
    pulse_tick();
    chk("run_235959", time24, 24'h235959);
    chk("pulse_cnt_59", 24'(pulse_cnt), 24'd1);
    pulse_cnt = 0;
    pulse_tick();
    chk("rollover_000000", time24, 24'h000000);
    chk("pulse_cnt_roll", 24'(pulse_cnt), 24'd1);

    // 12-hour instance: 12:59:00 -> 12:59:59 -> 01:00:00.
    reset = 1'b1;
    step();
    chk("rst12_again", time12, 24'h120000);
    reset = 1'b0;
    repeat (3) step();
    press_mode();
    repeat (12) press_up();
    chk("h12_mode_sethr", {22'd0, mode_b}, 24'd1);
    chk("h12_hr_wrap12", time12, 24'h120000);
    press_mode();
    repeat (59) press_up();
    press_mode();
    chk("h12_set_125900", time12, 24'h125900);
    repeat (59) pulse_tick();
    chk("h12_125959", time12, 24'h125959);
    pulse_tick();
    chk("h12_roll_010000", time12, 24'h010000);
    chk("h24_same_130000", time24, 24'h130000);

    // 37 s, then SET_HR with 25 increments; ticks frozen.
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (3) step();
    repeat (37) pulse_tick();
    chk("run_000037", time24, 24'h000037);
    press_up();
    chk("run_up_ignored", time24, 24'h000037);
    press_mode();
    repeat (25) press_up();
    chk("hr25_mode", {22'd0, mode_a}, 24'd1);
    chk("hr25_time24", time24, 24'h010037);
    chk("hr25_time12", time12, 24'h010037);
    pulse_cnt = 0;
    repeat (3) pulse_tick();
    chk("sethr_frozen", time24, 24'h010037);
    chk("sethr_no_pulse", 24'(pulse_cnt), 24'd0);

    // btn_mode and btn_up together in SET_HR.
    btn_mode = 1'b1;
    btn_up   = 1'b1;
    step();
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    chk("mode_prio_mode", {22'd0, mode_a}, 24'd2);
    chk("mode_prio_time", time24, 24'h010037);

    // Tick coincident with btn_mode in SET_MIN: tick dropped, seconds cleared.
    tick_in = 1'b1;
    step();
    step();
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    chk("setmin_tick_pulse", {23'd0, pulse_a}, 24'd0);
    chk("setmin_exit_mode", {22'd0, mode_a}, 24'd0);
    chk("setmin_exit_time", time24, 24'h010000);
    tick_in = 1'b0;
    repeat (3) step();
    chk("setmin_no_late", time24, 24'h010000);

    // Tick coincident with btn_mode in RUN: tick applied, mode to SET_HR.
    tick_in = 1'b1;
    step();
    step();
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    chk("run_tick_pulse", {23'd0, pulse_a}, 24'd1);
    chk("run_tick_mode", {22'd0, mode_a}, 24'd1);
    chk("run_tick_time", time24, 24'h010001);
    tick_in = 1'b0;
    repeat (3) step();
    press_mode();
    chk("to_setmin", {22'd0, mode_a}, 24'd2);

    // Async reset mid-SET_MIN with tick_in held high.
    tick_in = 1'b1;
    repeat (4) step();
    #2 reset = 1'b1;
    #1;
    chk("async_time24", time24, 24'h000000);
    chk("async_time12", time12, 24'h120000);
    chk("async_mode", {22'd0, mode_a}, 24'd0);
    step();
    reset = 1'b0;
    pulse_cnt = 0;
    repeat (6) step();
    chk("high_no_tick", time24, 24'h000000);
    chk("high_no_pulse", 24'(pulse_cnt), 24'd0);
    tick_in = 1'b0;
    repeat (3) step();
    tick_in = 1'b1;
    repeat (3) step();
    chk("rise_after_low", time24, 24'h000001);
    chk("rise_pulse_cnt", 24'(pulse_cnt), 24'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
